// File: rtl/ula_pkg.sv
// Shared constants for the 8-bit 74181-style ALU: mode select values and named function opcodes.
package ula_pkg;

   typedef logic [3:0] sel_t;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   localparam sel_t S_PASS_A = 4'b0000;
   localparam sel_t S_DEC    = 4'b1111;
   localparam sel_t S_ALL1   = 4'b0011;
   localparam sel_t S_SUB_M1 = 4'b0110;
   localparam sel_t S_ADD    = 4'b1001;
   localparam sel_t S_DOUBLE = 4'b1100;

   localparam sel_t S_NOT_A  = 4'b0000;
   localparam sel_t S_NOR    = 4'b0001;
   localparam sel_t S_ZERO   = 4'b0011;
   localparam sel_t S_NAND   = 4'b0100;
   localparam sel_t S_XOR    = 4'b0110;
   localparam sel_t S_XNOR   = 4'b1001;
   localparam sel_t S_AND    = 4'b1011;
   localparam sel_t S_ONES   = 4'b1100;
   localparam sel_t S_OR     = 4'b1110;

endpackage

// File: rtl/ula_8bits_if.sv
// Operand/result bundle of the ALU; master drives operands, slave returns registered results.
interface ula_8bits_if;
   import ula_pkg::*;

   logic [7:0] a;
   logic [7:0] b;
   sel_t       s;
   logic       m;
   logic       c_in;
   logic [7:0] f;
   logic       c_out;
   logic       a_eq_b;

   modport master (output a, b, s, m, c_in, input f, c_out, a_eq_b);
   modport slave  (input a, b, s, m, c_in, output f, c_out, a_eq_b);
endinterface

// File: rtl/ula_74181.sv
// 4-bit combinational 74181-style slice (active-high data); chains through cn/cn4.
module ula_74181
   import ula_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  sel_t       s,
   input  logic       m,
   input  logic       cn,
   output logic [3:0] f,
   output logic       cn4,
   output logic       p,
   output logic       g,
   output logic       aeqb
);

   logic [3:0] x;
   logic [3:0] y;
   logic [4:0] sum;
   logic [4:0] gen_sum;

   always_comb begin
      x       = '0;
      y       = '0;
      sum     = '0;
      gen_sum = '0;
      f       = '0;
      cn4     = 1'b0;
      p       = 1'b0;
      g       = 1'b0;
      if (m == MODE_LOGIC) begin
         case (s)
            4'b0000: f = ~a;
            4'b0001: f = ~(a | b);
            4'b0010: f = ~a & b;
            4'b0011: f = 4'h0;
            4'b0100: f = ~(a & b);
            4'b0101: f = ~b;
            4'b0110: f = a ^ b;
            4'b0111: f = a & ~b;
            4'b1000: f = ~a | b;
            4'b1001: f = ~(a ^ b);
            4'b1010: f = b;
            4'b1011: f = a & b;
            4'b1100: f = 4'hF;
            4'b1101: f = a | ~b;
            4'b1110: f = a | b;
            default: f = a;
         endcase
      end else begin
         case (s)
            4'b0000: begin x = a;      y = 4'h0;    end
            4'b0001: begin x = a | b;  y = 4'h0;    end
            4'b0010: begin x = a | ~b; y = 4'h0;    end
            4'b0011: begin x = 4'h0;   y = 4'hF;    end
            4'b0100: begin x = a;      y = a & ~b;  end
            4'b0101: begin x = a | b;  y = a & ~b;  end
            4'b0110: begin x = a;      y = ~b;      end
            4'b0111: begin x = a & ~b; y = 4'hF;    end
            4'b1000: begin x = a;      y = a & b;   end
            4'b1001: begin x = a;      y = b;       end
            4'b1010: begin x = a | ~b; y = a & b;   end
            4'b1011: begin x = a & b;  y = 4'hF;    end
            4'b1100: begin x = a;      y = a;       end
            4'b1101: begin x = a | b;  y = a;       end
            4'b1110: begin x = a | ~b; y = a;       end
            default: begin x = a;      y = 4'hF;    end
         endcase
         sum     = {1'b0, x} + {1'b0, y} + {4'b0, cn};
         gen_sum = {1'b0, x} + {1'b0, y};
         f       = sum[3:0];
         cn4     = sum[4];
         // group propagate/generate for an external lookahead unit: cn4 == g | (p & cn)
         p       = &(x ^ y);
         g       = gen_sum[4];
      end
   end

   assign aeqb = &f;

endmodule

// File: rtl/ula_8bits.sv
// 8-bit ALU built from two rippled 74181 slices, with registered f, c_out and all-ones flag.
module ula_8bits
   import ula_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   ula_8bits_if.slave  bus
);

   logic [3:0] f_lo;
   logic [3:0] f_hi;
   logic       c_mid;
   logic       c_hi;
   logic       aeq_lo;
   logic       aeq_hi;

   ula_74181 u_lo (
      .a    (bus.a[3:0]),
      .b    (bus.b[3:0]),
      .s    (bus.s),
      .m    (bus.m),
      .cn   (bus.c_in),
      .f    (f_lo),
      .cn4  (c_mid),
      .p    (),
      .g    (),
      .aeqb (aeq_lo)
   );

   ula_74181 u_hi (
      .a    (bus.a[7:4]),
      .b    (bus.b[7:4]),
      .s    (bus.s),
      .m    (bus.m),
      .cn   (c_mid),
      .f    (f_hi),
      .cn4  (c_hi),
      .p    (),
      .g    (),
      .aeqb (aeq_hi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.f      <= 8'h00;
         bus.c_out  <= 1'b0;
         bus.a_eq_b <= 1'b0;
      end else begin
         bus.f      <= {f_hi, f_lo};
         bus.c_out  <= c_hi;
         bus.a_eq_b <= aeq_lo & aeq_hi;
      end
   end

endmodule

// File: tb/tb_ula_8bits.sv
// Bench for ula_8bits: directed cases plus random operands against a whole-byte arithmetic model.
module tb_ula_8bits;
   import ula_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   ula_8bits_if bus ();

   ula_8bits dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns {a_eq_b, c_out, f}
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s, input logic m, input logic cin);
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] r;
      int         total;
      logic       co;
      co = 1'b0;
      if (m) begin
         case (s)
            4'd0:    r = ~a;
            4'd1:    r = ~(a | b);
            4'd2:    r = ~a & b;
            4'd3:    r = 8'h00;
            4'd4:    r = ~(a & b);
            4'd5:    r = ~b;
            4'd6:    r = a ^ b;
            4'd7:    r = a & ~b;
            4'd8:    r = ~a | b;
            4'd9:    r = ~(a ^ b);
            4'd10:   r = b;
            4'd11:   r = a & b;
            4'd12:   r = 8'hFF;
            4'd13:   r = a | ~b;
            4'd14:   r = a | b;
            default: r = a;
         endcase
      end else begin
         case (s)
            4'd0:    begin x = a;      y = 8'h00;  end
            4'd1:    begin x = a | b;  y = 8'h00;  end
            4'd2:    begin x = a | ~b; y = 8'h00;  end
            4'd3:    begin x = 8'h00;  y = 8'hFF;  end
            4'd4:    begin x = a;      y = a & ~b; end
            4'd5:    begin x = a | b;  y = a & ~b; end
            4'd6:    begin x = a;      y = ~b;     end
            4'd7:    begin x = a & ~b; y = 8'hFF;  end
            4'd8:    begin x = a;      y = a & b;  end
            4'd9:    begin x = a;      y = b;      end
            4'd10:   begin x = a | ~b; y = a & b;  end
            4'd11:   begin x = a & b;  y = 8'hFF;  end
            4'd12:   begin x = a;      y = a;      end
            4'd13:   begin x = a | b;  y = a;      end
            4'd14:   begin x = a | ~b; y = a;      end
            default: begin x = a;      y = 8'hFF;  end
         endcase
         total = int'(x) + int'(y) + int'(cin);
         r     = 8'(total % 256);
         co    = (total >= 256);
      end
      return {(r == 8'hFF), co, r};
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
      bus.a    = a;
      bus.b    = b;
      bus.s    = s;
      bus.m    = m;
      bus.c_in = cin;
   endtask

   task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
      logic [9:0] e;
      @(negedge clk);
      drive(a, b, s, m, cin);
      e = model(a, b, s, m, cin);
      @(posedge clk);
      #1;
      chk({tag, "_f"},   16'(bus.f),      16'(e[7:0]));
      chk({tag, "_co"},  16'(bus.c_out),  16'(e[8]));
      chk({tag, "_aeq"}, 16'(bus.a_eq_b), 16'(e[9]));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      drive(8'h00, 8'h00, 4'h0, MODE_ARITH, 1'b0);
      #12;
      chk("rst_f",   16'(bus.f),      16'h0);
      chk("rst_co",  16'(bus.c_out),  16'h0);
      chk("rst_aeq", 16'(bus.a_eq_b), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      apply("add61_85", 8'd61, 8'd85, S_ADD, MODE_ARITH, 1'b0);
      chk("add61_85_lit", 16'(bus.f), 16'd146);
      apply("add244_170", 8'd244, 8'd170, S_ADD, MODE_ARITH, 1'b1);
      chk("add244_170_lit", 16'(bus.f), 16'd159);
      chk("add244_170_co_lit", 16'(bus.c_out), 16'd1);
      apply("cmp_eq", 8'd122, 8'd122, S_SUB_M1, MODE_ARITH, 1'b0);
      chk("cmp_eq_lit", 16'(bus.a_eq_b), 16'd1);
      apply("cmp_eq_c1", 8'd122, 8'd122, S_SUB_M1, MODE_ARITH, 1'b1);
      chk("cmp_eq_c1_lit", 16'(bus.f), 16'h00);
      apply("xor_lit", 8'h3D, 8'h55, S_XOR, MODE_LOGIC, 1'b1);
      chk("xor_lit_f", 16'(bus.f), 16'h68);
      apply("m1_c0", 8'hA5, 8'h3C, S_ALL1, MODE_ARITH, 1'b0);
      chk("m1_c0_lit", 16'(bus.f), 16'hFF);
      apply("m1_c1", 8'hA5, 8'h3C, S_ALL1, MODE_ARITH, 1'b1);
      chk("m1_c1_lit", 16'(bus.c_out), 16'd1);

      for (int i = 0; i < 16; i++) begin
         apply($sformatf("logic_s%0d", i), 8'($urandom), 8'($urandom), 4'(i), MODE_LOGIC,
               1'($urandom));
         apply($sformatf("arith_s%0d", i), 8'($urandom), 8'($urandom), 4'(i), MODE_ARITH,
               1'($urandom));
      end

      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra;
         ra = 8'($urandom);
         // a==b often enough to exercise the all-ones flag
         apply("rand", ra, ($urandom_range(0, 3) == 0) ? ra : 8'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
      end

      apply("pre_rst", 8'd61, 8'd85, S_ADD, MODE_ARITH, 1'b0);
      chk("pre_rst_lit", 16'(bus.f), 16'h92);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_f",   16'(bus.f),      16'h0);
      chk("async_rst_co",  16'(bus.c_out),  16'h0);
      chk("async_rst_aeq", 16'(bus.a_eq_b), 16'h0);
      @(posedge clk);
      #1;
      chk("held_rst_f", 16'(bus.f), 16'h0);
      @(negedge clk);
      drive(8'd244, 8'd170, S_ADD, MODE_ARITH, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_f",  16'(bus.f),     16'd159);
      chk("post_rst_co", 16'(bus.c_out), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
